tibuf_reg_bank: RTL

//  WIDTH-bit registered tristate output bank with a bus-turnaround guard and pad readback.

---
 rtl/tibuf_reg_bank_pkg.sv | 19 +
 rtl/tibuf_turn_ctl.sv | 74 +++++++
 rtl/tibuf_reg_bank.sv | 66 ++++++
 3 files changed

// File: rtl/tibuf_reg_bank_pkg.sv
`timescale 1ns / 1ps
// Shared definitions for tristate output banks: turnaround FSM encodings and parameter limits.
package tibuf_reg_bank_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_DRIVE = 2'd2
   } turn_state_e;

   localparam int TURN_MAX  = 15;
   localparam int WIDTH_MAX = 64;

   // The counter must hold TURN_CYC itself; a zero turnaround still gets a 1-bit counter.
   function automatic int cnt_width(input int turn_cyc);
      return (turn_cyc < 1) ? 1 : $clog2(turn_cyc + 1);
   endfunction

endpackage

// File: rtl/tibuf_turn_ctl.sv
`timescale 1ns / 1ps
// Bus-turnaround guard: holds off drive for TURN_CYC dead cycles after a drive request.
module tibuf_turn_ctl
   import tibuf_reg_bank_pkg::*;
#(
   parameter int TURN_CYC = 1
) (
   input  logic SCLK,
   input  logic CD,
   input  logic T,
   output logic OE,
   output logic BUSY
);

   localparam int              CW       = cnt_width(TURN_CYC);
   localparam logic [CW-1:0]   CNT_LOAD = CW'(TURN_CYC);
   localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

   turn_state_e     state;
   logic [CW-1:0]   cnt;

   // T is a level request sampled on every edge; dropping it at any point abandons the
   // turnaround, so a later request always waits the full TURN_CYC again.
   always_ff @(posedge SCLK or posedge CD) begin
      if (CD) begin
         state <= ST_IDLE;
         cnt   <= '0;
         OE    <= 1'b0;
         BUSY  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (T) begin
                  if (TURN_CYC == 0) begin
                     state <= ST_DRIVE;
                     OE    <= 1'b1;
                  end else begin
                     state <= ST_WAIT;
                     cnt   <= CNT_LOAD;
                     BUSY  <= 1'b1;
                  end
               end
            end
            ST_WAIT: begin
               if (!T) begin
                  state <= ST_IDLE;
                  cnt   <= '0;
                  BUSY  <= 1'b0;
               end else if (cnt <= CNT_ONE) begin
                  state <= ST_DRIVE;
                  cnt   <= '0;
                  BUSY  <= 1'b0;
                  OE    <= 1'b1;
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end
            ST_DRIVE: begin
               if (!T) begin
                  state <= ST_IDLE;
                  OE    <= 1'b0;
               end
            end
            default: begin
               state <= ST_IDLE;
               cnt   <= '0;
               OE    <= 1'b0;
               BUSY  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/tibuf_reg_bank.sv
`timescale 1ns / 1ps
// Registered tristate output bank: DQ drives the pad bus through per-lane bufif1 once the
// turnaround guard grants the bus; DI samples the pad back.
`celldefine
module tibuf_reg_bank
   import tibuf_reg_bank_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int TURN_CYC = 1,
   parameter bit DI_GATE  = 1'b0
) (
   input  logic             SCLK,
   input  logic             CD,
   input  logic             SP,
   input  logic             T,
   input  logic [WIDTH-1:0] I,
   inout  wire  [WIDTH-1:0] O,
   output logic [WIDTH-1:0] DI,
   output logic             OE,
   output logic             BUSY
);

   logic [WIDTH-1:0] dq;

   if (WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_bad_width
      $error("tibuf_reg_bank: WIDTH=%0d outside 1..%0d", WIDTH, WIDTH_MAX);
   end
   if (TURN_CYC < 0 || TURN_CYC > TURN_MAX) begin : g_bad_turn
      $error("tibuf_reg_bank: TURN_CYC=%0d outside 0..%0d", TURN_CYC, TURN_MAX);
   end

   tibuf_turn_ctl #(
      .TURN_CYC (TURN_CYC)
   ) u_turn_ctl (
      .SCLK (SCLK),
      .CD   (CD),
      .T    (T),
      .OE   (OE),
      .BUSY (BUSY)
   );

   // SP only gates the data; the FSM keeps running, so drive may start with a stale DQ.
   always_ff @(posedge SCLK or posedge CD) begin
      if (CD) begin
         dq <= '0;
      end else if (SP) begin
         dq <= I;
      end
   end

   // Readback takes the pad as resolved, including Z or contended lanes.
   always_ff @(posedge SCLK or posedge CD) begin
      if (CD) begin
         DI <= '0;
      end else if (!DI_GATE || SP) begin
         DI <= O;
      end
   end

   // OE clears asynchronously with CD, so the pads release without waiting for an edge.
   for (genvar k = 0; k < WIDTH; k++) begin : g_lane
      bufif1 u_buf (O[k], dq[k], OE);
   end

endmodule
`endcelldefine
